// File: rtl/seg7_scan.sv
// Time-multiplexed hex driver for an 8-digit common-anode 7-segment display, double-buffered at frame boundaries.
// Optional LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan #(
   parameter int DIGITS = 8,
   parameter int DWELL  = 4,
   parameter int GAP    = 1
) (
   input  logic                  in_clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     en_mask,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic                  frame_done
);

   localparam int MAXC = (GAP > DWELL) ? GAP : DWELL;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   localparam logic [0:0] ST_GAP  = 1'b0;
   localparam logic [0:0] ST_SHOW = 1'b1;
   localparam logic [0:0] ST_INIT = (GAP > 0) ? ST_GAP : ST_SHOW;

   logic [0:0]          state;
   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] disp;
   logic [DIGITS-1:0]   disp_dp;
   logic [4*DIGITS-1:0] pend;
   logic [DIGITS-1:0]   pend_dp;
   logic                pend_vld;

   logic [3:0]          nib;
   logic                dig_dp;
   logic                dig_en;
   logic                dig_blank;
   logic                lit;
   logic                last_show;
   logic [DIGITS-1:0]   an_nxt;
`ifdef LEAD_ZERO_BLANK_EN
   logic                upper_zero;
`endif

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'h0: decode = 7'h40;
         4'h1: decode = 7'h79;
         4'h2: decode = 7'h24;
         4'h3: decode = 7'h30;
         4'h4: decode = 7'h19;
         4'h5: decode = 7'h12;
         4'h6: decode = 7'h02;
         4'h7: decode = 7'h78;
         4'h8: decode = 7'h00;
         4'h9: decode = 7'h10;
         4'hA: decode = 7'h08;
         4'hB: decode = 7'h03;
         4'hC: decode = 7'h46;
         4'hD: decode = 7'h21;
         4'hE: decode = 7'h06;
         default: decode = 7'h0E;
      endcase
   endfunction

   // Walk digits from the top so the leading-zero test accumulates downward.
   always_comb begin
      nib       = 4'h0;
      dig_dp    = 1'b0;
      dig_en    = 1'b0;
      dig_blank = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
      upper_zero = 1'b1;
`endif
      for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef LEAD_ZERO_BLANK_EN
         upper_zero = upper_zero & (disp[4*k +: 4] == 4'h0);
`endif
         if (idx == IW'(k)) begin
            nib    = disp[4*k +: 4];
            dig_dp = disp_dp[k];
            dig_en = en_mask[k];
`ifdef LEAD_ZERO_BLANK_EN
            dig_blank = (k != 0) && upper_zero;
`endif
         end
      end
   end

   assign lit       = (state == ST_SHOW) && dig_en && !dig_blank;
   assign last_show = (state == ST_SHOW) && (cnt == DWELL_LAST);

   always_comb begin
      an_nxt = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (lit && (idx == IW'(k))) an_nxt[k] = 1'b0;
      end
   end

   // State registers name the phase emitted at the next edge; outputs register that phase.
   always_ff @(posedge in_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_INIT;
         cnt        <= '0;
         idx        <= '0;
         an         <= '1;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         an         <= an_nxt;
         seg        <= lit ? decode(nib) : 7'h7F;
         dp         <= lit ? ~dig_dp : 1'b1;
         frame_done <= last_show && (idx == IDX_LAST);
         if (state == ST_GAP) begin
            if (cnt == GAP_LAST) begin
               state <= ST_SHOW;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else if (last_show) begin
            state <= ST_INIT;
            cnt   <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // frame_done marks the boundary cycle; a load landing there bypasses the pending buffer.
   always_ff @(posedge in_clk or negedge rst_n) begin
      if (!rst_n) begin
         disp     <= '0;
         disp_dp  <= '0;
         pend     <= '0;
         pend_dp  <= '0;
         pend_vld <= 1'b0;
      end else if (load) begin
         if (frame_done) begin
            disp     <= data;
            disp_dp  <= dp_in;
            pend_vld <= 1'b0;
         end else begin
            pend     <= data;
            pend_dp  <= dp_in;
            pend_vld <= 1'b1;
         end
      end else if (frame_done && pend_vld) begin
         disp     <= pend;
         disp_dp  <= pend_dp;
         pend_vld <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan (DIGITS=8, DWELL=4, GAP=1); expected outputs predicted per edge and checked 1 time unit later.
module tb_seg7_scan;

   logic        in_clk = 1'b0;
   logic        rst_n  = 1'b0;
   logic        load   = 1'b0;
   logic [31:0] data   = '0;
   logic [7:0]  dp_in  = '0;
   logic [7:0]  en_mask = 8'hFF;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;

   seg7_scan dut (
      .in_clk(in_clk), .rst_n(rst_n), .load(load), .data(data), .dp_in(dp_in),
      .en_mask(en_mask), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
   );

   always #5 in_clk = ~in_clk;

   // Reference model state: n is the index of the next rising edge since reset release.
   int          n = 0;
   logic [31:0] m_disp = '0, m_pend = '0;
   logic [7:0]  m_ddp = '0, m_pdp = '0;
   logic        m_pv = 1'b0;
   logic [16:0] exp_q[$];

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic predict(output logic [16:0] e);
      int q, d, r;
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic       show;
      logic [31:0] sh;
      q = n % 40;
      d = q / 5;
      r = q % 5;
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      show = (r >= 1) && en_mask[d];
`ifdef LEAD_ZERO_BLANK_EN
      sh = m_disp >> (4 * d);
      if (d > 0 && sh == 32'h0) show = 1'b0;
`else
      sh = 32'h0;
`endif
      if (show) begin
         e_an  = ~(8'h01 << d);
         e_seg = seg_tab[(m_disp >> (4 * d)) & 32'hF];
         e_dp  = ~m_ddp[d];
      end
      e = {e_an, e_seg, e_dp, (q == 39)};
      if (n > 0 && q == 0) begin
         if (load) begin
            m_disp = data; m_ddp = dp_in; m_pv = 1'b0;
         end else if (m_pv) begin
            m_disp = m_pend; m_ddp = m_pdp; m_pv = 1'b0;
         end
      end else if (load) begin
         m_pend = data; m_pdp = dp_in; m_pv = 1'b1;
      end
      n++;
   endtask

   task automatic step(input string tag);
      logic [16:0] e;
      predict(e);
      exp_q.push_back(e);
      @(posedge in_clk);
      #1;
      if (exp_q.size() == 0) chk({tag, "_qempty"}, 32'd1, 32'd0);
      else chk(tag, {15'h0, an, seg, dp, frame_done}, {15'h0, exp_q.pop_front()});
   endtask

   task automatic run(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) step(tag);
   endtask

   // Advance until the last completed edge sits at frame position pos (bounded).
   task automatic run_to(input string tag, input int pos);
      int guard = 0;
      while (((n - 1) % 40) != pos && guard < 100) begin
         step(tag);
         guard++;
      end
      if (guard >= 100) chk({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic pulse_load(input string tag, input logic [31:0] d, input logic [7:0] p);
      data = d; dp_in = p; load = 1'b1;
      step(tag);
      load = 1'b0;
   endtask

   task automatic reset_hold_check(input string tag);
      chk({tag, "_an"}, {24'h0, an}, 32'hFF);
      chk({tag, "_seg"}, {25'h0, seg}, 32'h7F);
      chk({tag, "_dp"}, {31'h0, dp}, 32'h1);
      chk({tag, "_fd"}, {31'h0, frame_done}, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         @(posedge in_clk);
         #1;
         reset_hold_check("rst");
      end
      rst_n = 1'b1;
      run("post_rst", 45);

      pulse_load("load1", 32'h1234_5678, 8'h01);
      run("scan1", 80);

      run_to("pre_mid", 14);
      pulse_load("load_aa", 32'hAAAA_AAAA, 8'h00);
      run_to("mid", 24);
      pulse_load("load_bb", 32'hBBBB_BBBB, 8'h00);
      run("scan_bb", 60);

      run_to("pre_bnd", 38);
      step("pre_bnd");
      pulse_load("load_bnd", 32'hFEDC_BA90, 8'h80);
      run("scan_bnd", 40);

      en_mask = 8'hF0;
      run("mask", 50);
      en_mask = 8'hFF;

      pulse_load("load_lz", 32'h0000_00A0, 8'h00);
      run("lead_zero", 80);

      pulse_load("load_pend", 32'h9999_9999, 8'hFF);
      run_to("to_d5", 27);
      rst_n = 1'b0;
      #1;
      reset_hold_check("mid_rst");
      exp_q.delete();
      n = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pv = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge in_clk);
         #1;
         reset_hold_check("mid_rst_hold");
      end
      rst_n = 1'b1;
      run("after_rst", 45);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
